roll_accumulator: RTL and testbench

- Decimating accumulator for the roll-mode display path.
- Sums `PRESCALER` consecutive valid input samples into a 42-bit window sum. Emits that sum once per window with a one-cycle strobe.
- Sits directly upstream of the roll-mode scaler, which reduces the 42-bit sum to a 12-bit screen value according to the same prescaler.
- Sets the roll speed: from real-time (prescaler ≤ 1) down to 1/65535 of real-time.

---
 rtl/roll_accumulator.sv | 85 ++++++++
 tb/tb_roll_accumulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/roll_accumulator.sv
// Decimating accumulator for the roll-mode display path: sums a window of
// max(prescaler,1) valid samples and emits the sum with a one-cycle strobe.
module roll_accumulator #(
    parameter int SAMPLE_W = 26,
    parameter int SUM_W    = 42,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CNT_W-1:0]    prescaler,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic [SUM_W-1:0]    value,
    output logic                out_valid,
    output logic                busy
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state, state_nx;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   sum_nx;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   win_len;
    logic [CNT_W-1:0]   win_len_nx;
    logic               last;

    // A prescaler of 0 behaves as 1 (real-time pass-through).
    assign win_len_nx = (prescaler == '0) ? CNT_W'(1) : prescaler;
    assign sum_nx     = acc + {{(SUM_W-SAMPLE_W){1'b0}}, in_sample};
    // Compare one bit wider so count+1 cannot wrap.
    assign last       = ({1'b0, count} + (CNT_W+1)'(1)) == {1'b0, win_len};
    assign busy       = (state == ACCUM) && (count != '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable)  state_nx = ACCUM;
            ACCUM:   if (!enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            win_len   <= CNT_W'(1);
            value     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    acc   <= '0;
                    count <= '0;
                    if (enable) win_len <= win_len_nx;
                end
                ACCUM: begin
                    if (!enable) begin
                        // Partial window is discarded; value holds.
                        acc   <= '0;
                        count <= '0;
                    end else if (in_valid) begin
                        if (last) begin
                            value     <= sum_nx;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            count     <= '0;
                            win_len   <= win_len_nx;
                        end else begin
                            acc   <= sum_nx;
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_roll_accumulator.sv
// Scoreboard bench for roll_accumulator: expected window sums are queued when
// the closing sample is driven and checked when out_valid pulses.
module tb_roll_accumulator;

    localparam int SAMPLE_W = 26;
    localparam int SUM_W    = 42;
    localparam int CNT_W    = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic [CNT_W-1:0]    prescaler = '0;
    logic                in_valid = 1'b0;
    logic [SAMPLE_W-1:0] in_sample = '0;
    logic [SUM_W-1:0]    value;
    logic                out_valid;
    logic                busy;

    int tests_run = 0;
    int failures  = 0;
    logic [SUM_W-1:0] sb[$];

    roll_accumulator #(.SAMPLE_W(SAMPLE_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .prescaler(prescaler),
        .in_valid(in_valid), .in_sample(in_sample),
        .value(value), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            tests_run++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: value=%h, no window expected", value);
            end else begin
                logic [SUM_W-1:0] exp_v;
                exp_v = sb.pop_front();
                if (value !== exp_v) begin
                    failures++;
                    $display("FAIL window_sum: got %h, expected %h", value, exp_v);
                end
            end
        end
    end

    // Drives one valid sample for one cycle; returns on the next negedge.
    task automatic send(input logic [SAMPLE_W-1:0] s, input bit closes,
                        input logic [SUM_W-1:0] exp_v);
        in_valid  = 1'b1;
        in_sample = s;
        if (closes) sb.push_back(exp_v);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Forces a fresh window start with the given prescaler.
    task automatic start(input logic [CNT_W-1:0] p);
        enable = 1'b0;
        @(negedge clk);
        prescaler = p;
        enable    = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d windows outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run += 3;
        if (value !== '0)     begin failures++; $display("FAIL reset_value: got %h, expected 0", value); end
        if (out_valid !== 0)  begin failures++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        if (busy !== 0)       begin failures++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        start(16'd4);
        send(26'd10, 0, '0);
        tests_run++;
        if (busy !== 1) begin failures++; $display("FAIL basic_busy_after_first: got %b, expected 1", busy); end
        send(26'd20, 0, '0);
        send(26'd30, 0, '0);
        send(26'd40, 1, 42'd100);
        tests_run += 2;
        if (out_valid !== 1) begin failures++; $display("FAIL basic_pulse_latency: got %b, expected 1", out_valid); end
        if (busy !== 0)      begin failures++; $display("FAIL basic_busy_after_last: got %b, expected 0", busy); end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 0) begin failures++; $display("FAIL basic_pulse_width: got %b, expected 0", out_valid); end
        drain("basic");
    endtask

    task automatic test_reset_mid_window();
        start(16'd4);
        send(26'd7, 0, '0);
        send(26'd8, 0, '0);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        tests_run += 3;
        if (value !== '0)    begin failures++; $display("FAIL midreset_value: got %h, expected 0", value); end
        if (out_valid !== 0) begin failures++; $display("FAIL midreset_out_valid: got %b, expected 0", out_valid); end
        if (busy !== 0)      begin failures++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        send(26'd1, 0, '0);
        send(26'd2, 0, '0);
        send(26'd3, 0, '0);
        send(26'd4, 1, 42'd10);
        drain("midreset");
    endtask

    task automatic test_pass_through();
        logic [CNT_W-1:0] ps[2];
        ps[0] = 16'd0;
        ps[1] = 16'd1;
        for (int k = 0; k < 2; k++) begin
            start(ps[k]);
            send(26'd5, 1, 42'd5);
            tests_run++;
            if (out_valid !== 1 || value !== 42'd5) begin
                failures++;
                $display("FAIL pass_first_p%0d: got vld=%b val=%h, expected 1/5", ps[k], out_valid, value);
            end
            send(26'd7, 1, 42'd7);
            tests_run++;
            if (out_valid !== 1 || value !== 42'd7) begin
                failures++;
                $display("FAIL pass_second_p%0d: got vld=%b val=%h, expected 1/7", ps[k], out_valid, value);
            end
            drain("pass");
        end
    endtask

    task automatic test_gapped();
        logic [SUM_W-1:0] tot = '0;
        start(16'd5);
        for (int i = 0; i < 5; i++) begin
            tot += 42'(i * 3 + 1);
            send(26'(i * 3 + 1), i == 4, tot);
            repeat (i % 3) @(negedge clk);
        end
        drain("gapped");
    endtask

    task automatic test_full_scale();
        start(16'd65535);
        for (int i = 0; i < 65535; i++) begin
            send(26'h3FFFFFF, i == 65534, 42'h3FFFBFF0001);
            if (i == 40000) begin
                tests_run++;
                if (busy !== 1) begin failures++; $display("FAIL full_busy: got %b, expected 1", busy); end
            end
        end
        drain("full_scale");
    endtask

    task automatic test_prescaler_change();
        start(16'd4);
        send(26'd1, 0, '0);
        send(26'd1, 0, '0);
        prescaler = 16'd2;
        send(26'd1, 0, '0);
        send(26'd1, 1, 42'd4);
        send(26'd3, 0, '0);
        send(26'd3, 1, 42'd6);
        drain("ps_change");
    endtask

    task automatic test_enable_drop();
        start(16'd3);
        send(26'd5, 0, '0);
        send(26'd5, 0, '0);
        enable    = 1'b0;
        in_valid  = 1'b1;
        in_sample = 26'd100;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (busy !== 0) begin failures++; $display("FAIL drop_busy: got %b, expected 0", busy); end
        enable = 1'b1;
        @(negedge clk);
        send(26'd9, 0, '0);
        send(26'd9, 0, '0);
        send(26'd9, 1, 42'd27);
        drain("enable_drop");
    endtask

    task automatic test_back_to_back();
        start(16'd2);
        send(26'd11, 0, '0);
        send(26'd12, 1, 42'd23);
        send(26'd13, 0, '0);
        send(26'd14, 1, 42'd27);
        // Window closes, then enable drops: the registered pulse must still show.
        send(26'd20, 0, '0);
        in_valid  = 1'b1;
        in_sample = 26'd21;
        sb.push_back(42'd41);
        @(negedge clk);
        in_valid = 1'b0;
        enable   = 1'b0;
        drain("b2b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_window();
        test_pass_through();
        test_gapped();
        test_prescaler_change();
        test_enable_drop();
        test_back_to_back();
        test_full_scale();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
